// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg
// Shared definitions for the SPI master transfer controller:
//   - default transfer width and slave-select delay
//   - FSM state encodings (plain localparams so older tools can use them)
//   - helper that sizes the SCLK edge counter for a given transfer width
package spi_ctrl_pkg;

    localparam int DEFAULT_DATA_W   = 8;
    localparam int DEFAULT_SS_DELAY = 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEAD  = 3'd1;
    localparam logic [2:0] ST_XFER  = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // The edge counter must be able to hold the value 2*data_w (one count
    // per sample strobe plus one per setup strobe).
    function automatic int edge_cnt_width(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_shift_register.sv
// spi_shift_register
// TX/RX shift register pair for one SPI transfer.
// Optional feature macro: SPI_CTRL_LSB_FIRST_EN (adds i_lsbfe bit-order select).
// Ports:
//   i_clk, i_reset_n   system clock, asynchronous active-low reset
//   i_load             load i_load_data into TX, clear RX (start of transfer)
//   i_load_data        byte to transmit
//   i_lsbfe            (macro only) LSB-first select, captured on i_load
//   i_shift_out        advance TX so the next bit appears on o_tx_bit
//   i_shift_in         shift i_miso into the RX register
//   i_miso             serial input bit
//   o_tx_bit           bit currently presented to MOSI
//   o_rx_data          received word, natural bit order
module spi_shift_register
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
`ifdef SPI_CTRL_LSB_FIRST_EN
    input  logic              i_lsbfe,
`endif
    input  logic              i_shift_out,
    input  logic              i_shift_in,
    input  logic              i_miso,
    output logic              o_tx_bit,
    output logic [DATA_W-1:0] o_rx_data
);

    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic              lsb_first;

`ifdef SPI_CTRL_LSB_FIRST_EN
    // Bit order is frozen at load so a register write mid-transfer
    // cannot scramble the word already on the wire.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lsb_first <= 1'b0;
        end else if (i_load) begin
            lsb_first <= i_lsbfe;
        end
    end
`else
    assign lsb_first = 1'b0;
`endif

    // TX register: the outgoing bit always sits at one end, and shifting
    // moves the next bit into that position.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            tx_sr <= '0;
        end else if (i_load) begin
            tx_sr <= i_load_data;
        end else if (i_shift_out) begin
            tx_sr <= lsb_first ? (tx_sr >> 1) : (tx_sr << 1);
        end
    end

    // RX register: for LSB-first transfers the bits enter from the MSB end,
    // so after a full word the first received bit lands in bit 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_sr <= '0;
        end else if (i_load) begin
            rx_sr <= '0;
        end else if (i_shift_in) begin
            rx_sr <= lsb_first ? {i_miso, rx_sr[DATA_W-1:1]}
                               : {rx_sr[DATA_W-2:0], i_miso};
        end
    end

    assign o_tx_bit  = lsb_first ? tx_sr[0] : tx_sr[DATA_W-1];
    assign o_rx_data = rx_sr;

endmodule

// File: rtl/spi_master_controller.sv
// spi_master_controller
// Sequences one SPI master transfer on top of spi_clock_generator: accepts a
// TX word, drives slave select, runs the SCLK divider, shifts MOSI/captures
// MISO on the generator's setup/sample strobes and reports the result.
// Optional feature macro: SPI_CTRL_LSB_FIRST_EN (adds i_lsbfe).
// Ports:
//   i_clk, i_reset_n        system clock, asynchronous active-low reset
//   i_spe, i_mstr, i_cpha   SPI enable, master mode, clock phase
//   i_tx_valid, i_tx_data   write request / data; o_tx_ready accepts it
//   o_rx_valid, o_rx_data   one-cycle received-word pulse / held data
//   o_spif, i_spif_clr      sticky transfer-complete flag and its clear
//   o_wcol, i_wcol_clr      sticky write-collision flag and its clear
//   o_busy                  transfer in progress
//   o_sclk_run              enables the SCLK divider (XFER only)
//   i_sample, i_setup       strobes from spi_clock_generator
//   o_ss_n, o_mosi, i_miso  SPI pins
//   i_lsbfe                 (macro only) LSB-first select
module spi_master_controller
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int SS_DELAY = DEFAULT_SS_DELAY
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_spe,
    input  logic              i_mstr,
    input  logic              i_cpha,
`ifdef SPI_CTRL_LSB_FIRST_EN
    input  logic              i_lsbfe,
`endif
    input  logic              i_tx_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    output logic              o_tx_ready,
    output logic              o_rx_valid,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_spif,
    input  logic              i_spif_clr,
    output logic              o_wcol,
    input  logic              i_wcol_clr,
    output logic              o_busy,
    output logic              o_sclk_run,
    input  logic              i_sample,
    input  logic              i_setup,
    output logic              o_ss_n,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int EDGE_W = edge_cnt_width(DATA_W);
    localparam int SAMP_W = $clog2(DATA_W + 1);
    localparam int DLY_W  = (SS_DELAY > 1) ? $clog2(SS_DELAY) : 1;

    localparam logic [EDGE_W:0]   EDGE_LAST = (EDGE_W+1)'(2 * DATA_W);
    localparam logic [SAMP_W-1:0] SAMP_FULL = SAMP_W'(DATA_W);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(SS_DELAY - 1);

    logic [2:0]        state;
    logic [DLY_W-1:0]  dly_cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [SAMP_W-1:0] sample_cnt;
    logic [SAMP_W-1:0] sample_cnt_eff;
    logic [EDGE_W:0]   edge_cnt_next;
    logic [DATA_W-1:0] rx_shift;
    logic              enabled;
    logic              accept;
    logic              in_xfer;
    logic              do_sample;
    logic              do_setup;
    logic              shift_out;
    logic              dly_done;
    logic              xfer_done;
    logic              spif_set;
    logic              wcol_set;
    logic              cpha_unused;

    // The phase only changes the order in which the generator issues its
    // strobes; the setup rule below is correct for both orders, so the
    // controller itself never needs to look at CPHA.
    assign cpha_unused = i_cpha;

    assign enabled    = i_spe & i_mstr;
    assign o_tx_ready = (state == ST_IDLE) & enabled;
    assign o_busy     = (state != ST_IDLE);
    assign accept     = i_tx_valid & o_tx_ready;
    assign in_xfer    = (state == ST_XFER);
    assign do_sample  = in_xfer & i_sample;
    assign do_setup   = in_xfer & i_setup;
    assign dly_done   = (dly_cnt == DLY_LAST);

    // A coincident sample is applied before the setup, so the setup decision
    // uses the sample count including this cycle's sample. The first setup
    // (nothing sampled yet, CPHA=1) and the last one (word complete, CPHA=0)
    // leave MOSI alone.
    assign sample_cnt_eff = sample_cnt + SAMP_W'(do_sample);
    assign shift_out      = do_setup & (sample_cnt_eff != '0) & (sample_cnt_eff < SAMP_FULL);
    assign edge_cnt_next  = {1'b0, edge_cnt} + (EDGE_W+1)'(do_sample) + (EDGE_W+1)'(do_setup);
    assign xfer_done      = (edge_cnt_next >= EDGE_LAST);

    assign spif_set = (state == ST_TRAIL) & dly_done & enabled;
    assign wcol_set = i_tx_valid & o_busy;

    spi_shift_register #(
        .DATA_W (DATA_W)
    ) u_shift (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_load      (accept),
        .i_load_data (i_tx_data),
`ifdef SPI_CTRL_LSB_FIRST_EN
        .i_lsbfe     (i_lsbfe),
`endif
        .i_shift_out (shift_out),
        .i_shift_in  (do_sample),
        .i_miso      (i_miso),
        .o_tx_bit    (o_mosi),
        .o_rx_data   (rx_shift)
    );

    // Transfer sequencer. Losing SPE or MSTR in any active state drops
    // straight back to IDLE with SS released and no completion reported.
    // SS, SCLK-run and the RX result are registered here so the pins never
    // glitch on state decode.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            dly_cnt    <= '0;
            edge_cnt   <= '0;
            sample_cnt <= '0;
            o_ss_n     <= 1'b1;
            o_sclk_run <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            o_rx_valid <= 1'b0;
            if ((state != ST_IDLE) && !enabled) begin
                state      <= ST_IDLE;
                dly_cnt    <= '0;
                o_ss_n     <= 1'b1;
                o_sclk_run <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state      <= ST_LEAD;
                            dly_cnt    <= '0;
                            edge_cnt   <= '0;
                            sample_cnt <= '0;
                            o_ss_n     <= 1'b0;
                        end
                    end
                    ST_LEAD: begin
                        if (dly_done) begin
                            state      <= ST_XFER;
                            dly_cnt    <= '0;
                            o_sclk_run <= 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt + DLY_W'(1);
                        end
                    end
                    ST_XFER: begin
                        edge_cnt   <= edge_cnt_next[EDGE_W-1:0];
                        sample_cnt <= sample_cnt_eff;
                        if (xfer_done) begin
                            state      <= ST_TRAIL;
                            o_sclk_run <= 1'b0;
                        end
                    end
                    ST_TRAIL: begin
                        if (dly_done) begin
                            state      <= ST_GAP;
                            dly_cnt    <= '0;
                            o_ss_n     <= 1'b1;
                            o_rx_valid <= 1'b1;
                            o_rx_data  <= rx_shift;
                        end else begin
                            dly_cnt <= dly_cnt + DLY_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (dly_done) begin
                            state   <= ST_IDLE;
                            dly_cnt <= '0;
                        end else begin
                            dly_cnt <= dly_cnt + DLY_W'(1);
                        end
                    end
                    default: begin
                        state      <= ST_IDLE;
                        o_ss_n     <= 1'b1;
                        o_sclk_run <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Sticky status flags; a set in the same cycle as a clear wins so an
    // event is never lost to a racing software clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_spif <= 1'b0;
            o_wcol <= 1'b0;
        end else begin
            if (spif_set) begin
                o_spif <= 1'b1;
            end else if (i_spif_clr) begin
                o_spif <= 1'b0;
            end
            if (wcol_set) begin
                o_wcol <= 1'b1;
            end else if (i_wcol_clr) begin
                o_wcol <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_controller.sv
// tb_spi_master_controller
// Self-checking bench for spi_master_controller. Plays the role of the clock
// generator (issuing setup/sample strobes in CPHA order) and of the slave
// (loopback or patterned MISO), and compares against a word-level model.
// Honours SPI_CTRL_LSB_FIRST_EN when defined.
module tb_spi_master_controller;

    localparam int DW      = 8;
    localparam int SSD     = 2;
    localparam int EDGES   = 2 * DW;
    localparam int TIMEOUT = 200;

    typedef struct {
        bit          cpha;
        bit          lsb;
        logic [DW-1:0] tx;
        bit          loopback;
        logic [DW-1:0] pattern;
        int          collide_edge;
        logic [DW-1:0] exp_rx;
        logic [DW-1:0] exp_seq;
    } vec_t;

    logic          clk = 1'b0;
    logic          i_reset_n = 1'b0;
    logic          i_spe = 1'b1;
    logic          i_mstr = 1'b1;
    logic          i_cpha = 1'b0;
`ifdef SPI_CTRL_LSB_FIRST_EN
    logic          i_lsbfe = 1'b0;
`endif
    logic          i_tx_valid = 1'b0;
    logic [DW-1:0] i_tx_data = '0;
    logic          o_tx_ready;
    logic          o_rx_valid;
    logic [DW-1:0] o_rx_data;
    logic          o_spif;
    logic          i_spif_clr = 1'b0;
    logic          o_wcol;
    logic          i_wcol_clr = 1'b0;
    logic          o_busy;
    logic          o_sclk_run;
    logic          i_sample = 1'b0;
    logic          i_setup = 1'b0;
    logic          o_ss_n;
    logic          o_mosi;
    logic          i_miso = 1'b0;

    int total_cnt = 0;
    int bad_cnt = 0;
    int ss_low_cnt = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!o_ss_n) ss_low_cnt++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    spi_master_controller #(
        .DATA_W   (DW),
        .SS_DELAY (SSD)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (i_reset_n),
        .i_spe      (i_spe),
        .i_mstr     (i_mstr),
        .i_cpha     (i_cpha),
`ifdef SPI_CTRL_LSB_FIRST_EN
        .i_lsbfe    (i_lsbfe),
`endif
        .i_tx_valid (i_tx_valid),
        .i_tx_data  (i_tx_data),
        .o_tx_ready (o_tx_ready),
        .o_rx_valid (o_rx_valid),
        .o_rx_data  (o_rx_data),
        .o_spif     (o_spif),
        .i_spif_clr (i_spif_clr),
        .o_wcol     (o_wcol),
        .i_wcol_clr (i_wcol_clr),
        .o_busy     (o_busy),
        .o_sclk_run (o_sclk_run),
        .i_sample   (i_sample),
        .i_setup    (i_setup),
        .o_ss_n     (o_ss_n),
        .o_mosi     (o_mosi),
        .i_miso     (i_miso)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act !== req) begin
            bad_cnt++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Wire order of a word: bit i of the serial stream is placed at position DW-1-i.
    function automatic logic [DW-1:0] modelSeq(input logic [DW-1:0] tx, input bit lsb);
        logic [DW-1:0] s;
        for (int i = 0; i < DW; i++) s[DW-1-i] = lsb ? tx[i] : tx[DW-1-i];
        return s;
    endfunction

    // Received word: k-th serial bit lands at position k (LSB first) or DW-1-k.
    function automatic logic [DW-1:0] modelRx(input logic [DW-1:0] tx, input logic [DW-1:0] pattern,
                                              input bit loopback, input bit lsb);
        logic [DW-1:0] r;
        logic [DW-1:0] wire_tx;
        logic          b;
        wire_tx = modelSeq(tx, lsb);
        for (int k = 0; k < DW; k++) begin
            b = loopback ? wire_tx[DW-1-k] : pattern[DW-1-k];
            if (lsb) r[k] = b;
            else     r[DW-1-k] = b;
        end
        return r;
    endfunction

    task automatic setLsb(input bit lsb);
`ifdef SPI_CTRL_LSB_FIRST_EN
        i_lsbfe = lsb;
`else
        if (lsb) $display("[TB] LSB-first request ignored in this build");
`endif
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ss_n"}, o_ss_n, 1);
        checkOutput({tag, "_mosi"}, o_mosi, 0);
        checkOutput({tag, "_sclk_run"}, o_sclk_run, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_rx_valid"}, o_rx_valid, 0);
        checkOutput({tag, "_rx_data"}, o_rx_data, 0);
        checkOutput({tag, "_spif"}, o_spif, 0);
        checkOutput({tag, "_wcol"}, o_wcol, 0);
    endtask

    // Waits for ready, then issues one accepted write; returns at cycle T+1.
    task automatic beginTransfer(input logic [DW-1:0] tx, input bit cpha, input bit lsb);
        int n;
        n = 0;
        while (!o_tx_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_wait", o_tx_ready, 1);
        ss_low_cnt = 0;
        i_cpha = cpha;
        setLsb(lsb);
        i_tx_valid = 1'b1;
        i_tx_data = tx;
        @(negedge clk);
        i_tx_valid = 1'b0;
    endtask

    task automatic waitSclkRun(output int n);
        n = 0;
        while (!o_sclk_run && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic driveEdges(input int count);
        for (int k = 0; k < count; k++) begin
            if (k % 2 == 0) i_sample = 1'b1;
            else            i_setup = 1'b1;
            @(negedge clk);
            i_sample = 1'b0;
            i_setup = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit keep_flags);
        int n;
        int samples;
        bit is_sample;
        logic [DW-1:0] cap;
        beginTransfer(v.tx, v.cpha, v.lsb);
        checkOutput("lead_ss_n", o_ss_n, 0);
        checkOutput("lead_busy", o_busy, 1);
        checkOutput("lead_mosi", o_mosi, v.exp_seq[DW-1]);
        waitSclkRun(n);
        checkOutput("lead_len", n, SSD);
        cap = '0;
        samples = 0;
        for (int k = 0; k < EDGES; k++) begin
            is_sample = v.cpha ? (k % 2 == 1) : (k % 2 == 0);
            if (is_sample) begin
                cap[DW-1-samples] = o_mosi;
                i_miso = v.loopback ? o_mosi : v.pattern[DW-1-samples];
                samples++;
                i_sample = 1'b1;
            end else begin
                i_setup = 1'b1;
            end
            if (k == v.collide_edge) begin
                i_tx_valid = 1'b1;
                i_tx_data = 8'h11;
            end
            @(negedge clk);
            i_sample = 1'b0;
            i_setup = 1'b0;
            if (k == v.collide_edge) begin
                i_tx_valid = 1'b0;
                checkOutput("wcol_set", o_wcol, 1);
            end
            if (k != EDGES - 1) @(negedge clk);
        end
        checkOutput("trail_sclk_run", o_sclk_run, 0);
        checkOutput("trail_ss_n", o_ss_n, 0);
        n = 0;
        while (!o_rx_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("trail_len", n, SSD);
        checkOutput("done_ss_n", o_ss_n, 1);
        checkOutput("rx_data", o_rx_data, v.exp_rx);
        checkOutput("spif_set", o_spif, 1);
        checkOutput("mosi_seq", cap, v.exp_seq);
        @(negedge clk);
        checkOutput("rx_valid_pulse", o_rx_valid, 0);
        checkOutput("rx_data_hold", o_rx_data, v.exp_rx);
        n = 1;
        while (!o_tx_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput("gap_len", n, SSD);
        checkOutput("ss_low_span", ss_low_cnt, 2 * SSD + 2 * EDGES - 1);
        if (!keep_flags) begin
            i_spif_clr = 1'b1;
            i_wcol_clr = 1'b1;
            @(negedge clk);
            i_spif_clr = 1'b0;
            i_wcol_clr = 1'b0;
            checkOutput("spif_clr", o_spif, 0);
            checkOutput("wcol_clr", o_wcol, 0);
        end
    endtask

    initial begin
        vec_t v;
        int n;
        int pulses;

        // Fixed vectors: loopback 0xA5 (CPHA=0), MISO tied high 0x3C (CPHA=1),
        // collision during 0x5A, loopback 0x81 (CPHA=1).
        vecs.push_back('{1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, -1, 8'hA5, 8'hA5});
        vecs.push_back('{1'b1, 1'b0, 8'h3C, 1'b0, 8'hFF, -1, 8'hFF, 8'h3C});
        vecs.push_back('{1'b0, 1'b0, 8'h5A, 1'b0, 8'h00,  6, 8'h00, 8'h5A});
        vecs.push_back('{1'b1, 1'b0, 8'h81, 1'b1, 8'h00, -1, 8'h81, 8'h81});
`ifdef SPI_CTRL_LSB_FIRST_EN
        vecs.push_back('{1'b0, 1'b1, 8'h01, 1'b1, 8'h00, -1, 8'h01, 8'h80});
`endif
        for (int i = 0; i < 6; i++) begin
            v.cpha = 1'($urandom_range(0, 1));
`ifdef SPI_CTRL_LSB_FIRST_EN
            v.lsb = 1'($urandom_range(0, 1));
`else
            v.lsb = 1'b0;
`endif
            v.tx = 8'($urandom);
            v.loopback = 1'($urandom_range(0, 1));
            v.pattern = 8'($urandom);
            v.collide_edge = -1;
            v.exp_seq = modelSeq(v.tx, v.lsb);
            v.exp_rx = modelRx(v.tx, v.pattern, v.loopback, v.lsb);
            vecs.push_back(v);
        end

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        i_reset_n = 1'b1;
        @(negedge clk);
        checkResetValues("post_reset");
        checkOutput("post_reset_ready", o_tx_ready, 1);

        foreach (vecs[i]) begin
            $display("[TB] vector %0d tx=0x%0h cpha=%0d lsb=%0d", i, vecs[i].tx, vecs[i].cpha, vecs[i].lsb);
            applyStimulus(vecs[i], 1'b0);
        end

        // Collision and clear in the same cycle: the set must win.
        beginTransfer(8'h22, 1'b0, 1'b0);
        i_tx_valid = 1'b1;
        i_tx_data = 8'h11;
        i_wcol_clr = 1'b1;
        @(negedge clk);
        i_tx_valid = 1'b0;
        i_wcol_clr = 1'b0;
        checkOutput("wcol_set_wins", o_wcol, 1);
        i_wcol_clr = 1'b1;
        @(negedge clk);
        i_wcol_clr = 1'b0;
        checkOutput("wcol_clear_alone", o_wcol, 0);
        i_mstr = 1'b0;
        @(negedge clk);
        checkOutput("mstr_abort_busy", o_busy, 0);
        checkOutput("mstr_abort_ss_n", o_ss_n, 1);
        i_mstr = 1'b1;

        // Leave SPIF set, then abort a transfer after 5 edges by dropping SPE.
        applyStimulus(vecs[0], 1'b1);
        beginTransfer(8'hC3, 1'b0, 1'b0);
        waitSclkRun(n);
        driveEdges(5);
        i_spe = 1'b0;
        @(negedge clk);
        checkOutput("abort_ss_n", o_ss_n, 1);
        checkOutput("abort_sclk_run", o_sclk_run, 0);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_spif", o_spif, 1);
        pulses = 0;
        for (int c = 0; c < 2 * SSD + 4; c++) begin
            if (o_rx_valid) pulses++;
            @(negedge clk);
        end
        checkOutput("abort_no_rx_valid", pulses, 0);
        checkOutput("abort_rx_data_kept", o_rx_data, 8'hA5);
        i_spe = 1'b1;

        // Asynchronous reset in the middle of XFER, with WCOL and SPIF set.
        beginTransfer(8'hFF, 1'b0, 1'b0);
        i_tx_valid = 1'b1;
        i_tx_data = 8'h11;
        @(negedge clk);
        i_tx_valid = 1'b0;
        waitSclkRun(n);
        driveEdges(3);
        checkOutput("pre_rst_mosi", o_mosi, 1);
        checkOutput("pre_rst_wcol", o_wcol, 1);
        #2;
        i_reset_n = 1'b0;
        #1;
        checkResetValues("async_rst");
        @(negedge clk);
        #2;
        i_reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(vecs[1], 1'b0);
        applyStimulus(vecs[vecs.size() - 1], 1'b0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/spi_master_controller.md
# spi_master_controller

Sequences one SPI master byte transfer on top of `spi_clock_generator`. It accepts a TX byte from the register interface, drives slave select, and runs and stops the SCLK divider. It uses the generator's `sample`/`setup` strobes to shift MOSI and capture MISO, then reports the result with a received byte, a sticky transfer-complete flag (SPIF) and a write-collision flag (WCOL). It sits between the AXI register bank and the clock generator and SPI pins.

## Interface
- `DATA_W`, 8, bits per transfer (≥2)
- `SS_DELAY`, 2, sys-clock cycles for each of lead (SS low→SCLK), trail (last edge→SS high) and gap (SS high→next accept); ≥1
- `i_clk` in 1: system clock
- `i_reset_n` in 1: asynchronous, active-low reset
- `i_spe`, `i_mstr`, `i_cpha` in 1 each: register controls (SPI enable, master mode, phase)
- `i_tx_valid` in 1, `i_tx_data` in DATA_W: write request; accepted when `i_tx_valid & o_tx_ready`
- `o_tx_ready` out 1: combinational `(state==IDLE) & i_spe & i_mstr`
- `o_rx_valid` out 1: one-cycle pulse; `o_rx_data` out DATA_W is valid with it and holds until the next pulse
- `o_spif` out 1: sticky done flag; `i_spif_clr` in 1 clears it
- `o_wcol` out 1: sticky collision flag; `i_wcol_clr` in 1 clears it
- `o_busy` out 1: state ≠ IDLE
- `o_sclk_run` out 1: high only in XFER; generator holds its divider reset and SCLK at idle level while low
- `i_sample`, `i_setup` in 1 each: one-cycle strobes from `spi_clock_generator`
- `o_ss_n` out 1, `o_mosi` out 1, `i_miso` in 1: SPI pins

## Operation
- FSM states: IDLE → LEAD → XFER → TRAIL → GAP → IDLE.
- **IDLE**
  - On accept: load the shift register with `i_tx_data`, clear the edge counter and sample counter, go to LEAD.
- **LEAD**
  - `o_ss_n`=0 and `o_mosi`=first bit (MSB).
  - After SS_DELAY cycles, go to XFER.
- **XFER**
  - Strobes are counted only in this state.
  - `i_sample`: shift `i_miso` into the RX register; increment the sample counter.
  - `i_setup`: shift the next TX bit onto `o_mosi` only if 0 < sample counter < DATA_W. This covers both phases: for CPHA=1 the first setup edge is a no-op; for CPHA=0 the last setup edge is a no-op.
  - Every strobe increments the edge counter. When it reaches 2·DATA_W, go to TRAIL.
  - If both strobes arrive in one cycle, the sample is applied first, then the setup.
- **TRAIL**
  - `o_sclk_run`=0, `o_ss_n` stays 0.
  - After SS_DELAY cycles, go to GAP.
- **GAP** (first cycle)
  - Pulse `o_rx_valid`, update `o_rx_data`, set `o_spif`, raise `o_ss_n`.
  - After SS_DELAY cycles, go to IDLE.
- **Flags**
  - A write with `i_tx_valid`=1 while `o_busy` sets `o_wcol`; the data is dropped.
  - When set and clear coincide, set wins (both flags).
- **Abort**
  - `i_spe` or `i_mstr` low in any non-IDLE state → IDLE next cycle.
  - `o_ss_n`=1, `o_sclk_run`=0, no `o_rx_valid`, SPIF unchanged.
- **Strobes outside XFER** are ignored.

## Timing
- Reset values:
  - FSM = IDLE
  - `o_ss_n`=1, `o_mosi`=0, `o_sclk_run`=0, `o_busy`=0
  - `o_rx_valid`=0, `o_rx_data`=0, `o_spif`=0, `o_wcol`=0
- Reset mid-transfer returns every output to its reset value immediately (asynchronous).
- Accept at cycle T:
  - T+1: `o_ss_n`=0, `o_busy`=1.
  - T+1+SS_DELAY: `o_sclk_run`=1.
- Final strobe at cycle E:
  - E+1: `o_sclk_run`=0.
  - E+1+SS_DELAY: `o_rx_valid` pulse, `o_ss_n`=1.
  - E+1+2·SS_DELAY: `o_tx_ready` high again.
- All outputs are registered except `o_tx_ready` and `o_busy`.

## Configuration
- Macro `SPI_CTRL_LSB_FIRST_EN`.
- Defined:
  - Adds input port `i_lsbfe` (1 bit).
  - When high, TX shifts out LSB first and RX fills from the MSB end, so `o_rx_data` is in natural bit order.
  - `i_lsbfe` is sampled only at accept; mid-transfer changes have no effect.
- Undefined: the port is absent and transfers are always MSB first.

## Structure
- Package `spi_ctrl_pkg` holds:
  - FSM state enum/localparams
  - default `DATA_W`, `SS_DELAY`
  - edge-counter width `$clog2(2*DATA_W+1)`
- Sub-module `spi_shift_register`:
  - TX/RX shift pair with load, shift-out and shift-in strobes
  - bit-order select when the macro is enabled

## Test plan
- CPHA=0, DATA_W=8, TX 0xA5, MISO loopback from MOSI → MOSI bits 1,0,1,0,0,1,0,1; `o_rx_data`=0xA5; exactly 16 strobes counted; SPIF=1.
- CPHA=1, TX 0x3C, MISO tied 1 → first setup strobe does not shift; `o_rx_data`=0xFF; `o_ss_n` low for (16 edges + 2·SS_DELAY) span.
- Write 0x11 while busy → `o_wcol`=1, 0x11 never transmitted; `i_wcol_clr` with a simultaneous new collision → `o_wcol` stays 1.
- `i_spe` dropped after 5 edges → next cycle `o_ss_n`=1, `o_sclk_run`=0, no `o_rx_valid`, `o_spif` unchanged.
- `i_reset_n` asserted mid-XFER → all outputs at reset values without a clock edge; new accept after release works normally.
- `SPI_CTRL_LSB_FIRST_EN` with `i_lsbfe`=1, TX 0x01 → MOSI first bit 1 then seven 0s; loopback `o_rx_data`=0x01.
